// File: rtl/spread_tx_modulator.sv
// Spread-spectrum BPSK transmitter: DDS carrier times a PRN chip stream, scaled
// by a programmable amplitude and emitted as signed 16-bit samples with a push strobe.

// Quarter-wave sine: maps phase index v (0..8191 across 0..pi/2) to 0..32767
// using the parabola 32767 * x * (2 - x), where x = v / 8192.
module sine (
   input  logic        [12:0] v,
   output logic signed [16:0] sv
);
   logic [25:0] p;

   assign p  = {13'd0, v} * (26'd16384 - {13'd0, v});
   assign sv = $signed(17'(p >> 11));
endmodule

module spread_tx_modulator #(
   parameter logic [31:0] BASE = 32'hFE000800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] Wdata,
   input  logic        write,
   input  logic        read,
   output logic [31:0] Rdata,
   output logic [15:0] DAC,
   output logic        PushDAC,
   output logic        EpochPulse
);
   // Output stream: PushDAC is a one-cycle valid with no ready; DAC holds between
   // pushes, and EpochPulse is only ever high together with PushDAC.

   logic        run;
   logic [31:0] sample_div, div_cnt;
   logic [31:0] freq_add, freq_phase;
   logic [31:0] chip_freq, chip_phase;
   logic [3:0]  prn_hob;
   logic [13:0] prn_poly, prn_value;
   logic [15:0] amplitude;
   logic [31:0] sample_count, epoch_count;

   logic        hit;
   logic [3:0]  off;
   logic        wr_ctrl, wr_div, wr_fadd, wr_fph, wr_cfrq, wr_cph, wr_prn, wr_amp, wr_scnt, wr_ecnt;

   assign hit     = (addr[31:6] == BASE[31:6]) && (addr[1:0] == 2'b00);
   assign off     = addr[5:2];
   assign wr_ctrl = write && hit && (off == 4'd0);
   assign wr_div  = write && hit && (off == 4'd1);
   assign wr_fadd = write && hit && (off == 4'd2);
   assign wr_fph  = write && hit && (off == 4'd3);
   assign wr_cfrq = write && hit && (off == 4'd4);
   assign wr_cph  = write && hit && (off == 4'd5);
   assign wr_prn  = write && hit && (off == 4'd6);
   assign wr_amp  = write && hit && (off == 4'd7);
   assign wr_scnt = write && hit && (off == 4'd8);
   assign wr_ecnt = write && hit && (off == 4'd9);

   always_comb begin
      Rdata = 32'd0;
      if (read && hit) begin
         case (off)
            4'd0:    Rdata = {31'd0, run};
            4'd1:    Rdata = sample_div;
            4'd2:    Rdata = freq_add;
            4'd3:    Rdata = freq_phase;
            4'd4:    Rdata = chip_freq;
            4'd5:    Rdata = chip_phase;
            4'd6:    Rdata = {prn_hob, prn_poly, prn_value};
            4'd7:    Rdata = {16'd0, amplitude};
            4'd8:    Rdata = sample_count;
            4'd9:    Rdata = epoch_count;
            default: Rdata = 32'd0;
         endcase
      end
   end

   logic        tick;
   logic [31:0] chip_phase_nx;
   logic        lfsr_step, ob, epoch_hit;
   logic [15:0] value_ext;
   logic [13:0] lfsr_t, value_nx;

   assign tick          = run && (div_cnt == sample_div);
   assign chip_phase_nx = chip_phase + chip_freq;
   // The PRN advances once per chip, on the rising crossing of the chip phase MSB.
   assign lfsr_step     = tick && !chip_phase[31] && chip_phase_nx[31];
   assign value_ext     = {2'b00, prn_value};
   assign ob            = value_ext[prn_hob];
   assign lfsr_t        = 14'((value_ext & ~(16'd1 << prn_hob)) << 1);
   assign value_nx      = ob ? (lfsr_t ^ prn_poly) : lfsr_t;
   assign epoch_hit     = lfsr_step && (value_nx == 14'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run          <= 1'b0;
         sample_div   <= 32'd0;
         div_cnt      <= 32'd0;
         freq_add     <= 32'd0;
         freq_phase   <= 32'd0;
         chip_freq    <= 32'd0;
         chip_phase   <= 32'd0;
         prn_hob      <= 4'd0;
         prn_poly     <= 14'd0;
         prn_value    <= 14'd0;
         amplitude    <= 16'd0;
         sample_count <= 32'd0;
         epoch_count  <= 32'd0;
      end else begin
         if (wr_ctrl) run <= Wdata[0];
         if (wr_div)  sample_div <= Wdata;
         if (wr_fadd) freq_add <= Wdata;
         if (wr_cfrq) chip_freq <= Wdata;
         if (wr_amp)  amplitude <= Wdata[15:0];

         if (!run || (div_cnt == sample_div)) div_cnt <= 32'd0;
         else                                 div_cnt <= div_cnt + 32'd1;

         // A bus write to a register beats that register's own tick update.
         if (wr_fph)    freq_phase <= Wdata;
         else if (tick) freq_phase <= freq_phase + freq_add;

         if (wr_cph)    chip_phase <= Wdata;
         else if (tick) chip_phase <= chip_phase_nx;

         if (wr_prn) begin
            prn_hob   <= Wdata[31:28];
            prn_poly  <= Wdata[27:14];
            prn_value <= Wdata[13:0];
         end else if (lfsr_step) begin
            prn_value <= value_nx;
         end

         if (wr_scnt)   sample_count <= Wdata;
         else if (tick) sample_count <= sample_count + 32'd1;

         if (wr_ecnt)        epoch_count <= 32'd0;
         else if (epoch_hit) epoch_count <= epoch_count + 32'd1;
      end
   end

   // Stage 0: capture table index, quadrant and chip from pre-update state.
   logic        s0_valid, s0_chip, s0_epoch;
   logic [12:0] s0_v;
   logic [1:0]  s0_quad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_v     <= 13'd0;
         s0_quad  <= 2'd0;
         s0_chip  <= 1'b0;
         s0_epoch <= 1'b0;
      end else begin
         s0_valid <= tick;
         if (tick) begin
            s0_v     <= freq_phase[30] ? ~freq_phase[29:17] : freq_phase[29:17];
            s0_quad  <= freq_phase[31:30];
            s0_chip  <= ob;
            s0_epoch <= epoch_hit;
         end
      end
   end

   // Stage 1: table lookup; lower half-wave and chip=1 each invert the sign.
   logic signed [16:0] sine_sv, s1_s;
   logic               s1_valid, s1_epoch;

   sine u_sine (
      .v  (s0_v),
      .sv (sine_sv)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_s     <= 17'sd0;
         s1_epoch <= 1'b0;
      end else begin
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_s     <= (s0_quad[1] ^ s0_chip) ? -sine_sv : sine_sv;
            s1_epoch <= s0_epoch;
         end
      end
   end

   // Stage 2: amplitude scaling, keeping product bits [31:16].
   logic signed [33:0] prod;
   logic               push_r, epoch_r;

   assign prod = s1_s * $signed({1'b0, amplitude});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         DAC     <= 16'd0;
         push_r  <= 1'b0;
         epoch_r <= 1'b0;
      end else begin
         push_r  <= s1_valid;
         epoch_r <= s1_valid && s1_epoch;
         if (s1_valid) DAC <= 16'(prod >> 16);
      end
   end

   assign PushDAC    = push_r;
   assign EpochPulse = push_r && epoch_r;
endmodule

// File: tb/tb_spread_tx_modulator.sv
// Directed bench for spread_tx_modulator: register map, tick timing, PRN chip
// sequence and epochs, carrier quadrants, amplitude scaling and reset behaviour.
module tb_spread_tx_modulator;
   localparam logic [31:0] BASE   = 32'hFE000800;
   localparam logic [31:0] R_CTRL = 32'h00, R_DIV = 32'h04, R_FADD = 32'h08, R_FPH = 32'h0C;
   localparam logic [31:0] R_CFRQ = 32'h10, R_CPH = 32'h14, R_PRN = 32'h18, R_AMP = 32'h1C;
   localparam logic [31:0] R_SCNT = 32'h20, R_ECNT = 32'h24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = 32'd0;
   logic [31:0] Wdata = 32'd0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] Rdata;
   logic [15:0] DAC;
   logic        PushDAC, EpochPulse;

   spread_tx_modulator #(.BASE(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .Wdata      (Wdata),
      .write      (write),
      .read       (read),
      .Rdata      (Rdata),
      .DAC        (DAC),
      .PushDAC    (PushDAC),
      .EpochPulse (EpochPulse)
   );

   // clock / reset
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // push log, sampled on the falling edge
   logic [31:0] push_cyc[$];
   logic [15:0] push_dac[$];
   logic        push_ep[$];
   always @(negedge clk) begin
      if (PushDAC) begin
         push_cyc.push_back(cyc);
         push_dac.push_back(DAC);
         push_ep.push_back(EpochPulse);
      end
   end

   task automatic clear_log();
      push_cyc.delete();
      push_dac.delete();
      push_ep.delete();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
      @(negedge clk);
      addr  = BASE + off;
      Wdata = data;
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic peek(input logic [31:0] off, output logic [31:0] data);
      addr = BASE + off;
      read = 1'b1;
      #1;
      data = Rdata;
      read = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
      @(negedge clk);
      peek(off, data);
   endtask

   // Exactly n >= 2 ticks at SampleDiv=0, then let the pipeline drain.
   task automatic run_ticks(input int n);
      bus_write(R_CTRL, 32'd1);
      repeat (n - 2) @(negedge clk);
      bus_write(R_CTRL, 32'd0);
      repeat (8) @(negedge clk);
   endtask

   // reference sample model
   function automatic logic [15:0] model_dac(input logic [31:0] ph, input logic chip,
                                             input logic [15:0] amp);
      int     v;
      longint sv, a, prod;
      v = int'(ph[29:17]);
      if (ph[30]) v = 8191 - v;
      sv = longint'((v * (16384 - v)) / 2048);
      if (ph[31] ^ chip) sv = -sv;
      a    = longint'(amp);
      prod = sv * a;
      return prod[31:16];
   endfunction

   int          seq[15] = '{1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9};
   logic [31:0] phases[6] = '{32'h20000000, 32'h60000000, 32'hA0000000, 32'hE0000000,
                              32'h00000000, 32'h80000000};

   initial begin
      logic [31:0] d, r_cyc;
      int          cur;
      logic        chip;

      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_dac", {16'd0, DAC}, 32'd0);
      check("rst_push", {31'd0, PushDAC}, 32'd0);
      check("rst_epoch", {31'd0, EpochPulse}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         bus_read(32'(i * 4), d);
         check($sformatf("rst_reg%0d", i), d, 32'd0);
      end
      repeat (100) @(negedge clk);
      check("rst_no_push", 32'(push_dac.size()), 32'd0);
      bus_write(32'h28, 32'hDEADBEEF);
      bus_read(32'h28, d);
      check("unmapped", d, 32'd0);
      bus_write(R_CTRL, 32'hFFFFFFFE);
      bus_read(R_CTRL, d);
      check("ctrl_bits", d, 32'd0);

      // divider timing with SampleDiv=3
      bus_write(R_DIV, 32'd3);
      addr = BASE + R_DIV;
      #1;
      check("read_low", Rdata, 32'd0);
      bus_read(R_DIV, d);
      check("div_rb", d, 32'd3);
      bus_write(R_CTRL, 32'd1);
      r_cyc = cyc;
      repeat (40) @(negedge clk);
      bus_write(R_CTRL, 32'd0);
      repeat (20) @(negedge clk);
      check("div_npush", 32'(push_cyc.size()), 32'd10);
      if (push_cyc.size() > 0) check("div_first", push_cyc[0], r_cyc + 32'd6);
      for (int i = 1; i < push_cyc.size(); i++)
         check($sformatf("div_gap%0d", i), push_cyc[i] - push_cyc[i-1], 32'd4);
      bus_read(R_SCNT, d);
      check("div_scnt", d, 32'd10);
      repeat (20) @(negedge clk);
      check("div_drained", 32'(push_cyc.size()), 32'd10);
      clear_log();

      // PRN sequence and epochs
      bus_write(R_DIV, 32'd0);
      bus_write(R_FADD, 32'd0);
      bus_write(R_FPH, 32'h20000000);
      bus_write(R_AMP, 32'h0000FFFF);
      bus_write(R_PRN, 32'h3000C001);
      bus_write(R_CFRQ, 32'h80000000);
      bus_write(R_CPH, 32'd0);
      bus_write(R_SCNT, 32'd0);
      bus_write(R_ECNT, 32'h12345678);
      bus_read(R_ECNT, d);
      check("ecnt_clear", d, 32'd0);
      bus_write(R_CTRL, 32'd1);
      for (int j = 0; j < 58; j++) begin
         peek(R_PRN, d);
         check($sformatf("prn_val%0d", j), d, 32'h3000C000 | 32'(seq[((j + 1) / 2) % 15]));
         @(negedge clk);
      end
      bus_write(R_CTRL, 32'd0);
      repeat (8) @(negedge clk);
      check("prn_npush", 32'(push_dac.size()), 32'd60);
      for (int k = 0; k < push_dac.size(); k++) begin
         cur  = seq[((k + 1) / 2) % 15];
         chip = cur[3];
         check($sformatf("prn_dac%0d", k), {16'd0, push_dac[k]},
               {16'd0, model_dac(32'h20000000, chip, 16'hFFFF)});
         check($sformatf("prn_ep%0d", k), {31'd0, push_ep[k]},
               {31'd0, (k == 28) || (k == 58)});
      end
      bus_read(R_ECNT, d);
      check("prn_ecnt", d, 32'd2);
      bus_read(R_SCNT, d);
      check("prn_scnt", d, 32'd60);
      bus_read(R_PRN, d);
      check("prn_final", d, 32'h3000C001);
      clear_log();

      // carrier quadrants and chip sign
      bus_write(R_CFRQ, 32'd0);
      for (int c = 0; c < 2; c++) begin
         bus_write(R_PRN, (c == 1) ? 32'h00000001 : 32'h00000000);
         for (int p = 0; p < 6; p++) begin
            bus_write(R_FPH, phases[p]);
            clear_log();
            run_ticks(2);
            check($sformatf("quad_n_c%0d_p%0d", c, p), 32'(push_dac.size()), 32'd2);
            if (push_dac.size() > 0)
               check($sformatf("quad_dac_c%0d_p%0d", c, p), {16'd0, push_dac[push_dac.size()-1]},
                     {16'd0, model_dac(phases[p], c[0], 16'hFFFF)});
         end
      end

      // amplitude scaling
      bus_write(R_PRN, 32'd0);
      bus_write(R_FPH, 32'h20000000);
      bus_write(R_AMP, 32'hABCD0000);
      bus_read(R_AMP, d);
      check("amp_rb", d, 32'd0);
      clear_log();
      run_ticks(4);
      check("amp0_n", 32'(push_dac.size()), 32'd4);
      for (int k = 0; k < push_dac.size(); k++)
         check($sformatf("amp0_dac%0d", k), {16'd0, push_dac[k]}, 32'd0);
      bus_write(R_AMP, 32'h00008000);
      clear_log();
      run_ticks(2);
      if (push_dac.size() > 0)
         check("amp_half", {16'd0, push_dac[push_dac.size()-1]}, 32'h00003000);
      else
         check("amp_half_n", 32'd0, 32'd2);

      // bus write colliding with a tick
      bus_write(R_FADD, 32'h00000100);
      bus_write(R_SCNT, 32'd0);
      bus_write(R_CTRL, 32'd1);
      bus_write(R_FPH, 32'h12345678);
      peek(R_FPH, d);
      check("coll_fph", d, 32'h12345678);
      peek(R_SCNT, d);
      check("coll_scnt", d, 32'd2);
      bus_write(R_CTRL, 32'd0);
      repeat (8) @(negedge clk);
      bus_read(R_FPH, d);
      check("coll_fph_end", d, 32'h12345878);
      bus_read(R_SCNT, d);
      check("coll_scnt_end", d, 32'd4);

      // asynchronous reset mid-pipeline
      bus_write(R_CTRL, 32'd1);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      clear_log();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_mid_push", 32'(push_dac.size()), 32'd0);
      check("rst_mid_dac", {16'd0, DAC}, 32'd0);
      bus_read(R_CTRL, d);
      check("rst_mid_ctrl", d, 32'd0);
      bus_read(R_SCNT, d);
      check("rst_mid_scnt", d, 32'd0);
      bus_read(R_FPH, d);
      check("rst_mid_fph", d, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
